// File: rtl/dds_sweep_scheduler.sv
// Chirp-shot sequencer for an AD9910: pulses io_update at a minimum repetition period,
// picks the sweep direction per shot and waits for DROVER plus a guard time between shots.
module dds_sweep_scheduler #(
    parameter int CLKNUM      = 2,
    parameter int IOUP_WIDTH  = 8,
    parameter int GUARD_CNT   = 504,
    parameter int TIMEOUT_CNT = 1_000_000,
    parameter int PERIOD_W    = 32
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                start,
    input  logic                stop,
    input  logic [PERIOD_W-1:0] period_cyc,
    input  logic [15:0]         burst_len,
    input  logic [1:0]          sweep_mode,
    input  logic                drover,
    output logic                io_update,
    output logic                sweep_sel,
    output logic                busy,
    output logic                done,
    output logic                timeout_err,
    output logic [15:0]         shot_cnt
);

    localparam int GUARD_W = $clog2(GUARD_CNT + 1);
    localparam int TMO_W   = $clog2(TIMEOUT_CNT + 1);

    localparam logic [PERIOD_W-1:0] IOUP_LAST  = PERIOD_W'(IOUP_WIDTH - 1);
    localparam logic [PERIOD_W-1:0] PERIOD_MIN = PERIOD_W'(IOUP_WIDTH + 2);
    localparam logic [GUARD_W-1:0]  GUARD_LAST = GUARD_W'(GUARD_CNT - 1);
    localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(TIMEOUT_CNT - 1);

    if (CLKNUM < 1 || IOUP_WIDTH < 1) begin : g_param_check
        $error("dds_sweep_scheduler: CLKNUM and IOUP_WIDTH must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ARM,
        S_WAIT_FALL,
        S_WAIT_GUARD,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                io_update_q, io_update_d;
    logic                sweep_sel_q, sweep_sel_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                timeout_err_q, timeout_err_d;
    logic [15:0]         shot_cnt_q, shot_cnt_d;
    logic                stop_pending_q, stop_pending_d;
    logic [1:0]          mode_q, mode_d;
    logic [15:0]         burst_q, burst_d;
    logic [PERIOD_W-1:0] period_last_q, period_last_d;
    logic [PERIOD_W-1:0] period_cnt_q, period_cnt_d;
    logic [GUARD_W-1:0]  guard_cnt_q, guard_cnt_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic                drover_s1_q, drover_s1_d;
    logic                drover_s2_q, drover_s2_d;
    logic                drover_h_q, drover_h_d;

    logic                drover_fall;
    logic [PERIOD_W-1:0] period_inc;
    logic [GUARD_W-1:0]  guard_inc;
    logic [TMO_W-1:0]    tmo_inc;
    logic                seq_end;

    // Mode 2 alternates starting with an up-sweep on shot index 0.
    function automatic logic dir_sel(input logic [1:0] mode, input logic odd_shot);
        case (mode)
            2'd1:    return 1'b0;
            2'd2:    return ~odd_shot;
            default: return 1'b1;
        endcase
    endfunction

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case infers a latch.
        state_d        = state_q;
        io_update_d    = io_update_q;
        sweep_sel_d    = sweep_sel_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        timeout_err_d  = timeout_err_q;
        shot_cnt_d     = shot_cnt_q;
        stop_pending_d = stop_pending_q;
        mode_d         = mode_q;
        burst_d        = burst_q;
        period_last_d  = period_last_q;
        period_cnt_d   = period_cnt_q;
        guard_cnt_d    = guard_cnt_q;
        tmo_cnt_d      = tmo_cnt_q;

        drover_s1_d = drover;
        drover_s2_d = drover_s1_q;
        drover_h_d  = drover_s2_q;
        drover_fall = drover_h_q & ~drover_s2_q;

        period_inc = (&period_cnt_q) ? period_cnt_q : period_cnt_q + PERIOD_W'(1);
        guard_inc  = (&guard_cnt_q)  ? guard_cnt_q  : guard_cnt_q + GUARD_W'(1);
        tmo_inc    = (&tmo_cnt_q)    ? tmo_cnt_q    : tmo_cnt_q + TMO_W'(1);
        seq_end    = stop_pending_q || stop || (burst_q != 16'd0 && shot_cnt_q == burst_q);

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d         = sweep_mode;
                    burst_d        = burst_len;
                    period_last_d  = ((period_cyc < PERIOD_MIN) ? PERIOD_MIN : period_cyc)
                                     - PERIOD_W'(1);
                    shot_cnt_d     = 16'd0;
                    timeout_err_d  = 1'b0;
                    stop_pending_d = 1'b0;
                    busy_d         = 1'b1;
                    sweep_sel_d    = dir_sel(sweep_mode, 1'b0);
                    state_d        = S_SETUP;
                end
            end
            S_SETUP: begin
                period_cnt_d = '0;
                tmo_cnt_d    = '0;
                io_update_d  = 1'b1;
                shot_cnt_d   = shot_cnt_q + 16'd1;
                state_d      = S_ARM;
            end
            S_ARM: begin
                period_cnt_d = period_inc;
                tmo_cnt_d    = tmo_inc;
                if (period_cnt_q >= IOUP_LAST) begin
                    io_update_d = 1'b0;
                    state_d     = S_WAIT_FALL;
                end
            end
            S_WAIT_FALL: begin
                period_cnt_d = period_inc;
                tmo_cnt_d    = tmo_inc;
                if (drover_fall) begin
                    guard_cnt_d = '0;
                    state_d     = S_WAIT_GUARD;
                end else if (tmo_inc >= TMO_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_DONE;
                end
            end
            S_WAIT_GUARD: begin
                period_cnt_d = period_inc;
                guard_cnt_d  = guard_inc;
                // The period is only a floor: a late DROVER pushes the next shot out.
                if (guard_cnt_q >= GUARD_LAST && period_cnt_q >= period_last_q) begin
                    if (seq_end) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        sweep_sel_d = dir_sel(mode_q, shot_cnt_q[0]);
                        state_d     = S_SETUP;
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (stop && state_q inside {S_SETUP, S_ARM, S_WAIT_FALL, S_WAIT_GUARD}) begin
            stop_pending_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q        <= S_IDLE;
            io_update_q    <= 1'b0;
            sweep_sel_q    <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            timeout_err_q  <= 1'b0;
            shot_cnt_q     <= '0;
            stop_pending_q <= 1'b0;
            mode_q         <= '0;
            burst_q        <= '0;
            period_last_q  <= '0;
            period_cnt_q   <= '0;
            guard_cnt_q    <= '0;
            tmo_cnt_q      <= '0;
            drover_s1_q    <= 1'b0;
            drover_s2_q    <= 1'b0;
            drover_h_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            io_update_q    <= io_update_d;
            sweep_sel_q    <= sweep_sel_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            timeout_err_q  <= timeout_err_d;
            shot_cnt_q     <= shot_cnt_d;
            stop_pending_q <= stop_pending_d;
            mode_q         <= mode_d;
            burst_q        <= burst_d;
            period_last_q  <= period_last_d;
            period_cnt_q   <= period_cnt_d;
            guard_cnt_q    <= guard_cnt_d;
            tmo_cnt_q      <= tmo_cnt_d;
            drover_s1_q    <= drover_s1_d;
            drover_s2_q    <= drover_s2_d;
            drover_h_q     <= drover_h_d;
        end
    end

    assign io_update   = io_update_q;
    assign sweep_sel   = sweep_sel_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = timeout_err_q;
    assign shot_cnt    = shot_cnt_q;

endmodule

// File: tb/tb_dds_sweep_scheduler.sv
// Bench for dds_sweep_scheduler: directed and random shot sequences against a
// shot-timing model (next rise = max(period floor, drover fall + sync + guard)).
module tb_dds_sweep_scheduler;

    localparam int IOUP  = 8;
    localparam int GUARD = 504;
    localparam int TMO   = 1000;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        start;
    logic        stop;
    logic [31:0] period_cyc;
    logic [15:0] burst_len;
    logic [1:0]  sweep_mode;
    logic        drover;
    logic        io_update;
    logic        sweep_sel;
    logic        busy;
    logic        done;
    logic        timeout_err;
    logic [15:0] shot_cnt;

    dds_sweep_scheduler #(
        .CLKNUM      (2),
        .IOUP_WIDTH  (IOUP),
        .GUARD_CNT   (GUARD),
        .TIMEOUT_CNT (TMO),
        .PERIOD_W    (32)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .start       (start),
        .stop        (stop),
        .period_cyc  (period_cyc),
        .burst_len   (burst_len),
        .sweep_mode  (sweep_mode),
        .drover      (drover),
        .io_update   (io_update),
        .sweep_sel   (sweep_sel),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .shot_cnt    (shot_cnt)
    );

    always #1 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;

    // Observations collected by the monitor for the current sequence.
    int rise_q[$];
    int width_q[$];
    bit sel_q[$];
    bit pre_q[$];
    int dly_q[$];
    int dl[$];
    int done_cnt, done_cyc, tmo_cyc, idle_cyc, sel_glitch;
    int s_cyc;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor plus DROVER model: DROVER goes high at each io_update rise and
    // falls a per-shot delay later (never, if no delay is queued).
    initial begin
        int  fall_at = -1;
        int  hi_len = 0;
        logic prev_io = 1'b0, prev_sel = 1'b0, prev_tmo = 1'b0, prev_busy = 1'b0;
        drover = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (io_update === 1'b1 && prev_io !== 1'b1) begin
                rise_q.push_back(cyc);
                sel_q.push_back(sweep_sel);
                pre_q.push_back(prev_sel);
                hi_len = 0;
                drover = 1'b1;
                fall_at = (dly_q.size() > 0) ? cyc + dly_q.pop_front() : -1;
            end else if (cyc == fall_at) begin
                drover = 1'b0;
            end
            if (io_update === 1'b1) hi_len++;
            if (io_update !== 1'b1 && prev_io === 1'b1) width_q.push_back(hi_len);
            if (io_update === 1'b1 && prev_io === 1'b1 && sweep_sel !== prev_sel) sel_glitch++;
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (timeout_err === 1'b1 && prev_tmo !== 1'b1) tmo_cyc = cyc;
            if (busy !== 1'b1 && prev_busy === 1'b1) idle_cyc = cyc;
            prev_io   = io_update;
            prev_sel  = sweep_sel;
            prev_tmo  = timeout_err;
            prev_busy = busy;
        end
    end

    task automatic start_seq(input int p, input int b, input int m, input bit with_stop);
        @(negedge sys_clk);
        rise_q.delete();
        width_q.delete();
        sel_q.delete();
        pre_q.delete();
        done_cnt   = 0;
        sel_glitch = 0;
        done_cyc   = -1;
        tmo_cyc    = -1;
        idle_cyc   = -1;
        dly_q      = dl;
        period_cyc = p;
        burst_len  = 16'(b);
        sweep_mode = 2'(m);
        start      = 1'b1;
        stop       = with_stop;
        s_cyc      = cyc;
        @(negedge sys_clk);
        start      = 1'b0;
        stop       = 1'b0;
        // Configuration must have been latched; scramble the live inputs.
        period_cyc = $urandom;
        burst_len  = 16'($urandom);
        sweep_mode = 2'($urandom);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(negedge sys_clk);
            k++;
        end
        check({tag, ":ends_in_budget"}, longint'(k < budget), 1);
        repeat (3) @(negedge sys_clk);
    endtask

    // Model: first rise 2 cycles after start; each later rise (or the end of the
    // sequence) comes at max(rise + Peff + 1, rise + drover_delay + 3 + GUARD + 1).
    task automatic check_seq(input string tag, input int p, input int n,
                             input bit exp_tmo, input int mode);
        int peff, er, last, nxt;
        bit es;
        peff = (p > IOUP + 2) ? p : IOUP + 2;
        er   = s_cyc + 2;
        last = er;
        check({tag, ":shots"}, rise_q.size(), n);
        check({tag, ":pulses"}, width_q.size(), n);
        for (int k = 0; k < n; k++) begin
            es = (mode == 1) ? 1'b0 : ((mode == 2) ? ((k % 2) == 0) : 1'b1);
            if (k < rise_q.size()) begin
                check($sformatf("%s:rise%0d", tag, k), rise_q[k], er);
                check($sformatf("%s:sel%0d", tag, k), sel_q[k], es);
                check($sformatf("%s:sel_setup%0d", tag, k), pre_q[k], es);
            end
            if (k < width_q.size()) check($sformatf("%s:width%0d", tag, k), width_q[k], IOUP);
            last = er;
            if (k < dl.size()) begin
                nxt = er + peff + 1;
                if (er + dl[k] + GUARD + 4 > nxt) nxt = er + dl[k] + GUARD + 4;
                er = nxt;
            end
        end
        if (exp_tmo) begin
            check({tag, ":tmo_cycle"}, tmo_cyc, last + TMO - 1);
            check({tag, ":busy_fall"}, idle_cyc, last + TMO);
            check({tag, ":no_done"}, done_cnt, 0);
            check({tag, ":tmo_sticky"}, timeout_err, 1);
        end else begin
            check({tag, ":done_pulses"}, done_cnt, 1);
            check({tag, ":done_cycle"}, done_cyc, er - 1);
            check({tag, ":busy_fall"}, idle_cyc, er);
            check({tag, ":no_tmo"}, timeout_err, 0);
        end
        check({tag, ":shot_cnt"}, shot_cnt, n);
        check({tag, ":sel_stable"}, sel_glitch, 0);
    endtask

    initial begin
        int k, p, b, m;
        sys_rst    = 1'b1;
        start      = 1'b0;
        stop       = 1'b0;
        period_cyc = '0;
        burst_len  = '0;
        sweep_mode = '0;
        repeat (4) @(negedge sys_clk);
        check("rst:io_update", io_update, 0);
        check("rst:sweep_sel", sweep_sel, 0);
        check("rst:busy", busy, 0);
        check("rst:done", done, 0);
        check("rst:timeout_err", timeout_err, 0);
        check("rst:shot_cnt", shot_cnt, 0);
        sys_rst = 1'b0;
        repeat (3) @(negedge sys_clk);

        // Three-shot burst, period-limited spacing.
        dl = '{600, 600, 600};
        start_seq(2000, 3, 0, 1'b0);
        wait_idle("burst", 10000);
        check_seq("burst", 2000, 3, 1'b0, 0);
        if (rise_q.size() >= 2) check("burst:gap", rise_q[1] - rise_q[0], 2001);

        // Alternating direction.
        dl.delete();
        repeat (4) dl.push_back($urandom_range(20, 800));
        p = $urandom_range(600, 1000);
        start_seq(p, 4, 2, 1'b0);
        wait_idle("alt", 8000);
        check_seq("alt", p, 4, 1'b0, 2);

        // Late DROVER stretches the spacing beyond the period.
        dl = '{900, 900};
        start_seq(500, 2, 0, 1'b0);
        wait_idle("late", 5000);
        check_seq("late", 500, 2, 1'b0, 0);
        if (rise_q.size() >= 2)
            check("late:gap_min", longint'((rise_q[1] - rise_q[0]) >= 900 + 3 + 504 + 1), 1);

        // DROVER never falls.
        dl.delete();
        start_seq(300, 3, 1, 1'b0);
        wait_idle("tmo", 3000);
        check_seq("tmo", 300, 1, 1'b1, 1);

        // Continuous run stopped during shot 5's WAIT_FALL; start clears timeout_err.
        dl.delete();
        repeat (8) dl.push_back($urandom_range(20, 400));
        start_seq(700, 0, 3, 1'b0);
        check("stop:tmo_cleared", timeout_err, 0);
        check("stop:busy", busy, 1);
        k = 0;
        while (rise_q.size() < 5 && k < 10000) begin
            @(negedge sys_clk);
            k++;
        end
        check("stop:reach_shot5", longint'(rise_q.size() >= 5), 1);
        if (rise_q.size() >= 5) begin
            while (cyc < rise_q[4] + 12) @(negedge sys_clk);
            stop = 1'b1;
            @(negedge sys_clk);
            stop = 1'b0;
        end
        wait_idle("stop", 3000);
        check_seq("stop", 700, 5, 1'b0, 3);

        // Reset while io_update is high.
        dl = '{300, 300};
        start_seq(400, 2, 0, 1'b0);
        k = 0;
        while (io_update !== 1'b1 && k < 20) begin
            @(negedge sys_clk);
            k++;
        end
        @(negedge sys_clk);
        check("rstarm:pre_io", io_update, 1);
        check("rstarm:pre_cnt", shot_cnt, 1);
        check("rstarm:pre_sel", sweep_sel, 1);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        check("rstarm:io_update", io_update, 0);
        check("rstarm:busy", busy, 0);
        check("rstarm:sweep_sel", sweep_sel, 0);
        check("rstarm:shot_cnt", shot_cnt, 0);
        repeat (20) @(negedge sys_clk);
        check("rstarm:stays_idle", busy, 0);

        // Stop in IDLE, start+stop together, and a start while busy: all ignored.
        @(negedge sys_clk);
        stop = 1'b1;
        @(negedge sys_clk);
        stop = 1'b0;
        dl = '{100, 100};
        start_seq(600, 2, 2, 1'b1);
        k = 0;
        while (rise_q.size() < 1 && k < 20) begin
            @(negedge sys_clk);
            k++;
        end
        if (rise_q.size() >= 1) begin
            while (cyc < rise_q[0] + 12) @(negedge sys_clk);
            start      = 1'b1;
            period_cyc = 50;
            burst_len  = 16'd0;
            sweep_mode = 2'd1;
            @(negedge sys_clk);
            start = 1'b0;
        end
        wait_idle("ignore", 4000);
        check_seq("ignore", 600, 2, 1'b0, 2);

        // Random sequences; the first uses a period below the clamp.
        for (int i = 0; i < 3; i++) begin
            p = (i == 0) ? $urandom_range(0, 9) : $urandom_range(0, 1500);
            b = $urandom_range(1, 3);
            m = $urandom_range(0, 3);
            dl.delete();
            for (int j = 0; j < b; j++) dl.push_back($urandom_range(20, 900));
            start_seq(p, b, m, 1'b0);
            wait_idle($sformatf("rnd%0d", i), 8000);
            check_seq($sformatf("rnd%0d", i), p, b, 1'b0, m);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, observed cyc=%0d expected finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
